// File: rtl/line_xfer_pkg.sv
// ---------------------------------------------------------------------------
// line_xfer_pkg
// Shared definitions for the cache-line transfer sequencer.
//   state_t     : sequencer states
//   LINE_WORDS  : words per cache line
//   OFFSET_W    : word-within-line address bits
//   line_base() : clears the word offset of an address (up to MAX_AW bits)
// ---------------------------------------------------------------------------
package line_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_BEAT = 3'd1,
        WR_BEAT = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } state_t;

    localparam int LINE_WORDS = 4;
    localparam int OFFSET_W   = 2;
    localparam int MAX_AW     = 32;

    // Callers zero-extend their address to MAX_AW bits and truncate the result
    // back, so one function serves every address width up to MAX_AW.
    function automatic logic [MAX_AW-1:0] line_base(input logic [MAX_AW-1:0] addr);
        return {addr[MAX_AW-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/xfer_timeout_ctr.sv
// ---------------------------------------------------------------------------
// xfer_timeout_ctr
// Counts cycles a memory beat has waited for ready.
//   clock, reset_n : clock, asynchronous active-low reset
//   i_clr          : restart the count (new transfer or completed beat)
//   i_en           : beat is waiting this cycle
//   o_expire       : this waiting cycle is the last one allowed
// ---------------------------------------------------------------------------
module xfer_timeout_ctr #(
    parameter int LIMIT = 15,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [CW-1:0] r_cnt;

    // Expiry is flagged on the LIMIT-th consecutive waiting cycle.
    assign o_expire = i_en && (r_cnt == CW'(LIMIT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/line_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// line_xfer_ctrl
// Sequences 4-word line refills and write-backs between cache and memory.
//   clock, reset_n        : clock, asynchronous active-low reset
//   rd_start / wr_start   : single-cycle start pulses from the cache (IDLE only)
//   line_addr             : any word address within the target line
//   cache_wdata           : write-back word for the current beat_idx
//   beat_idx              : word index of the current memory beat
//   fill_data/idx/valid   : registered refill word returned to the cache
//   busy, done, err       : transfer status; err coincides with done
//   rd_mem, wr_mem        : memory strobes, held across beats
//   addr_mem, mem_wdata   : memory word address / write data
//   mem_rdata, ready_mem  : memory read data / per-beat accept
// ---------------------------------------------------------------------------
module line_xfer_ctrl
    import line_xfer_pkg::*;
#(
    parameter int AWIDTH  = 9,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rd_start,
    input  logic              wr_start,
    input  logic [AWIDTH-1:0] line_addr,
    input  logic [DWIDTH-1:0] cache_wdata,
    output logic [1:0]        beat_idx,
    output logic [DWIDTH-1:0] fill_data,
    output logic [1:0]        fill_idx,
    output logic              fill_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_mem,
    output logic              wr_mem,
    output logic [AWIDTH-1:0] addr_mem,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              ready_mem
);

    localparam int TCW = $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [OFFSET_W-1:0] r_beat;
    logic [AWIDTH-1:0]   r_base;
    logic                r_fill_valid;
    logic [DWIDTH-1:0]   r_fill_data;
    logic [1:0]          r_fill_idx;

    logic w_in_beat;
    logic w_beat_ok;
    logic w_last_ok;
    logic w_accept;
    logic w_tmo_expire;

    assign w_in_beat = (r_state == RD_BEAT) || (r_state == WR_BEAT);
    assign w_beat_ok = w_in_beat && ready_mem;
    assign w_last_ok = w_beat_ok && (r_beat == OFFSET_W'(LINE_WORDS - 1));
    assign w_accept  = (r_state == IDLE) && (rd_start || wr_start);

    xfer_timeout_ctr #(
        .LIMIT (TIMEOUT),
        .CW    (TCW)
    ) u_tmo (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_clr    (w_accept || w_beat_ok),
        .i_en     (w_in_beat && !ready_mem),
        .o_expire (w_tmo_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                // Write-back wins a simultaneous start; the cache re-issues the refill.
                if (wr_start)      w_state_nxt = WR_BEAT;
                else if (rd_start) w_state_nxt = RD_BEAT;
            end
            RD_BEAT, WR_BEAT: begin
                if (w_last_ok)         w_state_nxt = DONE;
                else if (w_tmo_expire) w_state_nxt = ERR;
            end
            DONE, ERR: w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_base  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_beat <= '0;
                r_base <= AWIDTH'(line_base(MAX_AW'(line_addr)));
            end else if (w_beat_ok && !w_last_ok) begin
                // The final beat leaves the counter at 3 rather than wrapping.
                r_beat <= r_beat + OFFSET_W'(1);
            end
        end
    end

    // Refill words are captured on the accepted beat and presented next cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fill_valid <= 1'b0;
            r_fill_data  <= '0;
            r_fill_idx   <= '0;
        end else begin
            r_fill_valid <= w_beat_ok && (r_state == RD_BEAT);
            if (w_beat_ok && (r_state == RD_BEAT)) begin
                r_fill_data <= mem_rdata;
                r_fill_idx  <= r_beat;
            end
        end
    end

    assign beat_idx   = r_beat;
    assign fill_data  = r_fill_data;
    assign fill_idx   = r_fill_idx;
    assign fill_valid = r_fill_valid;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE) || (r_state == ERR);
    assign err        = (r_state == ERR);
    assign rd_mem     = (r_state == RD_BEAT);
    assign wr_mem     = (r_state == WR_BEAT);
    // Base offset bits are zero, so OR-ing in the beat forms the word address.
    assign addr_mem   = w_in_beat ? (r_base | AWIDTH'(r_beat)) : '0;
    assign mem_wdata  = (r_state == WR_BEAT) ? cache_wdata : '0;

endmodule

// File: doc/line_xfer_ctrl.md
Name: line_xfer_ctrl

Overview:
Sequences 4-word cache-line transfers between the 2-way set-associative cache and main memory. It replaces the free-running address-select counter that sat between them. It accepts a single-cycle refill or write-back start from the cache and walks the four word addresses with a per-beat ready handshake. It returns refill words to the cache, signals completion, and flags memory timeouts.

Parameters:
AWIDTH, 9, address width (word address; low 2 bits = word within line)
DWIDTH, 8, data word width
TIMEOUT, 15, max cycles a beat may wait for ready_mem before error (>=1)

Ports:
clock  in  1  system clock
reset_n  in  1  reset
rd_start  in  1  cache pulse: start line refill
wr_start  in  1  cache pulse: start line write-back
line_addr  in  AWIDTH  any address within target line (sampled with start)
cache_wdata  in  DWIDTH  write-back word for current beat_idx (combinational from cache)
beat_idx  out  2  word index of current memory beat
fill_data  out  DWIDTH  refill word
fill_idx  out  2  word index of fill_data
fill_valid  out  1  fill_data/fill_idx valid (one cycle per word)
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle timeout pulse (coincident with done)
rd_mem  out  1  memory read strobe
wr_mem  out  1  memory write strobe
addr_mem  out  AWIDTH  memory word address
mem_wdata  out  DWIDTH  memory write data
mem_rdata  in  DWIDTH  memory read data
ready_mem  in  1  memory beat accept/complete

Behaviour:
- Interface: single clock `clock`. Asynchronous, active-low reset `reset_n`.
- Reset (any time, including mid-transfer):
  - State goes to IDLE.
  - All outputs go to 0: beat counter, timeout counter, fill regs, strobes, busy, done, err, addr_mem.
  - No done is emitted for the aborted transfer.
- States:
  - IDLE: busy=0. Starts are accepted only here.
    - wr_start -> WR_BEAT.
    - rd_start -> RD_BEAT.
    - Both high: WR_BEAT wins; the rd_start is dropped, and the cache re-issues it after done.
    - On accept: base = {line_addr[AWIDTH-1:2],2'b00}; beat=0; timeout count=0.
  - RD_BEAT / WR_BEAT: busy=1; rd_mem (or wr_mem)=1; addr_mem = {base[AWIDTH-1:2], beat}; beat_idx=beat; mem_wdata=cache_wdata (wr only, else 0).
    - Cycle with ready_mem=1 completes the beat; beat increments and timeout count clears.
    - The strobe stays high across beats while the address advances.
    - Beat 3 completing -> DONE.
    - ready_mem=0 and timeout count==TIMEOUT-1 -> ERR. Otherwise the count increments.
  - DONE: strobes 0, busy=1, done=1 for one cycle -> IDLE.
  - ERR: strobes 0, busy=1, done=1, err=1 for one cycle -> IDLE. Partial refill words already delivered stand; the cache must discard the line on err.
- Refill data:
  - On a read-beat cycle with ready_mem=1, the next cycle has fill_valid=1, fill_data=mem_rdata (registered) and fill_idx=beat.
  - Last fill_valid coincides with done.
- Starts while busy=1 are ignored, with no side effects.
- Latency, with ready_mem tied high and start at cycle 0:
  - Strobe high cycles 1-4, addr_mem base+0..3.
  - done at cycle 5.
  - Read: fill_valid cycles 2-5.
- Minimum start-to-start interval: 6 cycles. IDLE at cycle 6 may accept a new start.
- Width rules:
  - beat counter is 2 bits and never wraps past 3 within a transfer.
  - Timeout counter width is $clog2(TIMEOUT+1).
  - addr_mem upper bits never change within a transfer.

Decomposition:
- Package line_xfer_pkg holds:
  - state enum {IDLE, RD_BEAT, WR_BEAT, DONE, ERR}
  - LINE_WORDS=4
  - OFFSET_W=2
  - a line-base address function
- Optional sub-module xfer_timeout_ctr, holding the per-beat counter with clear/enable/expire. Everything else stays in one module.

Test Plan:
- Refill, ready_mem tied 1, line_addr=9'h0A7, mem returns addr LSB byte -> rd_mem cycles 1-4, addr_mem 0A4,0A5,0A6,0A7; fill_valid cycles 2-5 with fill_idx 0-3 and matching data; done at cycle 5; err=0.
- Write-back, ready_mem low 2 cycles per beat, cache_wdata=8'h10+beat_idx -> memory receives 10,11,12,13 at 0x1F0..0x1F3; done exactly 1 cycle after 4th ready.
- rd_start and wr_start same cycle, line_addr=0x040 -> wr_mem sequence only, done once, busy drops; rd_start pulse during busy ignored (no rd_mem).
- ready_mem held 0 on beat 2 of a refill, TIMEOUT=15 -> fill_valid for words 0,1 only; strobe high 15 cycles on beat 2; err=done=1 one cycle; then IDLE.
- reset_n pulsed low mid-beat 1 of write-back -> wr_mem, busy, addr_mem go 0 asynchronously; no done; next wr_start runs full 4 beats from word 0.
- Back-to-back: second rd_start at cycle 6 after first done -> accepted; second rd_mem begins cycle 7.
